// File: rtl/seq_det_scheduler.sv
// rtl/seq_det_scheduler.sv - round-robin time-multiplexed serial pattern detector
module seq_det_scheduler #(
    parameter int              NCH     = 4,
    parameter int              PLEN    = 4,
    parameter int              CNTW    = 8,
    parameter logic [PLEN-1:0] PAT_RST = 4'b1101,
    parameter logic            OVL_RST = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_we,
    input  logic [PLEN-1:0]         cfg_pattern,
    input  logic                    cfg_overlap,
    input  logic [NCH-1:0]          ch_valid,
    input  logic [NCH-1:0]          ch_bit,
    output logic [NCH-1:0]          ch_ready,
    output logic                    match_valid,
    output logic [$clog2(NCH)-1:0]  match_ch,
    output logic [NCH*CNTW-1:0]     match_cnt
);
    localparam int IW = $clog2(NCH);
    localparam int FW = $clog2(PLEN);
    localparam logic [FW-1:0] FILL_MAX = FW'(PLEN - 1);

    logic [PLEN-1:0] pattern;
    logic            overlap;
    logic [IW-1:0]   rr_ptr;
    logic [PLEN-2:0] hist [NCH];
    logic [FW-1:0]   fill [NCH];
    logic [CNTW-1:0] cnt  [NCH];

    logic            gnt_any;
    logic [IW-1:0]   gnt_idx;
    logic [IW-1:0]   ptr_next;
    logic [PLEN-1:0] cand;
    logic            hit;
    int              idx;

    // Search upward from the pointer with wrap; config and reset block all grants.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int k = 0; k < NCH; k++) begin
            idx = (int'(rr_ptr) + k) % NCH;
            if (!gnt_any && ch_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = IW'(idx);
            end
        end
        if (rst || cfg_we) begin
            gnt_any = 1'b0;
        end
    end

    always_comb begin
        ch_ready = '0;
        if (gnt_any) begin
            ch_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        cand     = {hist[gnt_idx], ch_bit[gnt_idx]};
        hit      = gnt_any && (fill[gnt_idx] == FILL_MAX) && (cand == pattern);
        ptr_next = (gnt_idx == IW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pattern     <= PAT_RST;
            overlap     <= OVL_RST;
            rr_ptr      <= '0;
            match_valid <= 1'b0;
            match_ch    <= '0;
            for (int i = 0; i < NCH; i++) begin
                hist[i] <= '0;
                fill[i] <= '0;
                cnt[i]  <= '0;
            end
        end else if (cfg_we) begin
            pattern     <= cfg_pattern;
            overlap     <= cfg_overlap;
            rr_ptr      <= '0;
            match_valid <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                hist[i] <= '0;
                fill[i] <= '0;
                cnt[i]  <= '0;
            end
        end else begin
            match_valid <= hit;
            if (gnt_any) begin
                hist[gnt_idx] <= cand[PLEN-2:0];
                rr_ptr        <= ptr_next;
                // Non-overlapping hits discard history so the next match needs PLEN fresh bits.
                if (hit && !overlap) begin
                    fill[gnt_idx] <= '0;
                end else if (fill[gnt_idx] != FILL_MAX) begin
                    fill[gnt_idx] <= fill[gnt_idx] + 1'b1;
                end
                if (hit) begin
                    match_ch <= gnt_idx;
                    if (cnt[gnt_idx] != {CNTW{1'b1}}) begin
                        cnt[gnt_idx] <= cnt[gnt_idx] + 1'b1;
                    end
                end
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_cnt
        assign match_cnt[i*CNTW +: CNTW] = cnt[i];
    end

endmodule
